// File: rtl/tn_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter sharing one slave port between
// SERV ibus and dbus, with a watchdog that force-completes a hung transfer.
module tn_wb_arbiter #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic [AW-1:0] i_ibus_adr,
  input  logic          i_ibus_cyc,
  output logic [31:0]   o_ibus_rdt,
  output logic          o_ibus_ack,
  input  logic [AW-1:0] i_dbus_adr,
  input  logic [31:0]   i_dbus_dat,
  input  logic [3:0]    i_dbus_sel,
  input  logic          i_dbus_we,
  input  logic          i_dbus_cyc,
  output logic [31:0]   o_dbus_rdt,
  output logic          o_dbus_ack,
  output logic [AW-1:0] o_mem_adr,
  output logic [31:0]   o_mem_dat,
  output logic [3:0]    o_mem_sel,
  output logic          o_mem_we,
  output logic          o_mem_cyc,
  input  logic [31:0]   i_mem_rdt,
  input  logic          i_mem_ack,
  output logic          o_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] wdog_q, wdog_d;
  logic       err_q, err_d;

  logic gnt_i, gnt_d, cyc, tmo, done, fwd;

  assign gnt_i = (state_q == GNT_I);
  assign gnt_d = (state_q == GNT_D);
  assign cyc   = (gnt_i & i_ibus_cyc) | (gnt_d & i_dbus_cyc);
  assign tmo   = (wdog_q == 8'(TIMEOUT - 1));
  assign done  = cyc & (i_mem_ack | tmo);
  // A real ack always wins over a coincident timeout.
  assign fwd   = i_mem_ack | ~tmo;

  assign o_ibus_ack = gnt_i & i_ibus_cyc & (i_mem_ack | tmo);
  assign o_dbus_ack = gnt_d & i_dbus_cyc & (i_mem_ack | tmo);
  assign o_ibus_rdt = (gnt_i & fwd) ? i_mem_rdt : 32'd0;
  assign o_dbus_rdt = (gnt_d & fwd) ? i_mem_rdt : 32'd0;

  assign o_mem_cyc = cyc;
  assign o_mem_adr = gnt_d ? i_dbus_adr : i_ibus_adr;
  assign o_mem_dat = gnt_d ? i_dbus_dat : 32'd0;
  assign o_mem_sel = gnt_d ? i_dbus_sel : 4'd0;
  assign o_mem_we  = gnt_d & i_dbus_we;
  assign o_err     = err_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        wdog_d = 8'd0;
        unique case (1'b1)
          (i_ibus_cyc & ~i_dbus_cyc): state_d = GNT_I;
          (~i_ibus_cyc & i_dbus_cyc): state_d = GNT_D;
          (i_ibus_cyc & i_dbus_cyc):  state_d = last_q ? GNT_I : GNT_D;
          default:                    state_d = IDLE;
        endcase
      end
      GNT_I, GNT_D: begin
        if (!cyc) begin
          state_d = IDLE;
          wdog_d  = 8'd0;
        end else if (done) begin
          state_d = IDLE;
          wdog_d  = 8'd0;
          last_d  = gnt_d;
          if (!i_mem_ack) err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdog_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/tn_wb_arbiter.md
Name: tn_wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that lets the SERV core's instruction bus and data bus share a single RAM port, so one servant_ram-style memory holds both code and data.
- Grants one master at a time with round-robin fairness and holds the grant until the slave acks.
- Watchdog converts a missing slave ack into a zero-data ack plus a sticky error flag, so the core cannot hang.
- Sits between serv_rf_top and the shared RAM/peripheral decode in the top level.

Parameters:
- AW, 32, address width of masters and slave port.
- TIMEOUT, 255, max cycles a granted transfer waits for i_mem_ack before forced completion (1..255).

Ports:
- clk  in  1  system clock
- i_rst  in  1  asynchronous reset, active-high
- i_ibus_adr  in  AW  instruction fetch address
- i_ibus_cyc  in  1  instruction request
- o_ibus_rdt  out  32  instruction read data
- o_ibus_ack  out  1  instruction ack
- i_dbus_adr  in  AW  data address
- i_dbus_dat  in  32  data write data
- i_dbus_sel  in  4  data byte enables
- i_dbus_we  in  1  data write enable
- i_dbus_cyc  in  1  data request
- o_dbus_rdt  out  32  data read data
- o_dbus_ack  out  1  data ack
- o_mem_adr  out  AW  shared slave address
- o_mem_dat  out  32  shared slave write data
- o_mem_sel  out  4  shared slave byte enables
- o_mem_we  out  1  shared slave write enable
- o_mem_cyc  out  1  shared slave request
- i_mem_rdt  in  32  slave read data
- i_mem_ack  in  1  slave ack
- o_err  out  1  sticky timeout flag

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D. Registers: state, last (0=ibus, 1=dbus), 8-bit wdog counter, err.
- Reset values: state=IDLE, last=1 (ibus wins the first tie), wdog=0, err=0.
- Outputs while in reset: o_mem_cyc=0, both acks 0, o_err=0.
- IDLE transitions:
  - Only ibus_cyc -> GNT_I.
  - Only dbus_cyc -> GNT_D.
  - Both -> grant the master that is not `last`.
  - Neither -> stay in IDLE.
  - Grant decision registered: 1 cycle arbitration latency.
- GNT_x slave outputs:
  - o_mem_cyc = i_x_cyc.
  - adr/dat/sel/we muxed from the granted master.
  - ibus grant drives dat=0, sel=0, we=0.
- In IDLE: o_mem_cyc=0, o_mem_we=0; other mem outputs are don't-care, but the mux still selects ibus.
- Ack path:
  - o_x_ack = i_mem_ack & (state==GNT_x) & i_x_cyc, combinational.
  - o_x_rdt = i_mem_rdt when granted, else 0.
  - The non-granted master's ack is always 0.
- On ack: state -> IDLE next edge, last <= granted master, wdog <= 0. The master drops cyc the cycle after ack; at least one IDLE cycle separates grants.
- Abort: granted master drops cyc before ack -> IDLE next edge, no ack, last unchanged.
- Watchdog:
  - wdog increments each GNT cycle without ack.
  - When wdog==TIMEOUT-1 and still no ack, that cycle emits o_x_ack=1 with o_x_rdt=0, sets err<=1, and -> IDLE with last updated.
  - A late i_mem_ack arriving in IDLE is ignored.
- o_err stays set until i_rst.
- i_mem_ack in the same cycle as the timeout counts as a normal ack: real data, err unchanged.
- Async reset mid-transfer: immediate return to IDLE, o_mem_cyc drops combinationally from state, no ack emitted.

Test Plan:
- Ibus only, adr=0x10, slave acks 1 cycle after cyc with rdt=0xDEADBEEF:
  - o_mem_cyc rises 1 cycle after i_ibus_cyc.
  - o_ibus_ack=1 with rdt=0xDEADBEEF in the same cycle as i_mem_ack.
  - o_dbus_ack stays 0.
- Both cyc asserted together from reset:
  - ibus granted first, then dbus.
  - On a repeated tie, grants alternate I,D,I,D across 4 transfers; no starvation.
- Dbus write adr=0x100, dat=0x5, sel=0xF, we=1:
  - o_mem_adr/dat/sel/we match exactly while granted.
  - Concurrent ibus_cyc does not change o_mem_adr until after the dbus ack.
- TIMEOUT=4, slave never acks:
  - o_dbus_ack pulses on the 4th granted cycle with rdt=0.
  - o_err=1 and stays 1 through 3 further normal transfers.
- Dbus drops cyc after 2 granted cycles with no ack:
  - FSM returns to IDLE, no ack issued.
  - A following ibus request is granted next.
- i_rst pulsed mid GNT_D:
  - o_mem_cyc=0 immediately, o_err=0.
  - After release, the first tie goes to ibus.
